// File: rtl/alloc_requester_pkg.sv
// Shared definitions for the cell-allocator requester: defaults, FSM encodings
// and the allocator address-window check.
package alloc_requester_pkg;

    localparam logic [15:0] UNDEF         = 16'h0000;
    localparam logic [15:0] BASE_ADDR_DEF = 16'h5000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Offset is taken modulo 2**16, so addresses below the base wrap high and fail.
    function automatic logic in_window(input logic [15:0] addr,
                                       input logic [15:0] base,
                                       input int          addr_sz);
        logic [16:0] off;
        off = {1'b0, addr - base};
        return off < (17'd1 << addr_sz);
    endfunction

endpackage

// File: rtl/alloc_requester_sync_fifo.sv
// Single-clock FIFO with registered full/empty; push while full and pop while
// empty are ignored. DEPTH must be a power of two, at least 2.
module alloc_requester_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alloc_requester.sv
// Host-side front end for the cell allocator: alloc handshake FSM plus a queued
// free path. Define ALLOC_REQ_COMBINE_EN to let frees issue alongside o_alloc.
//
// state | meaning
// IDLE  | ready for a host alloc request
// ISSUE | o_alloc strobe with latched data, latency counter loaded
// WAIT  | counting down allocator latency, address captured at terminal count
// RESP  | response held until the host consumes it
module alloc_requester
    import alloc_requester_pkg::*;
#(
    parameter int          ADDR_SZ    = 4,
    parameter logic [15:0] BASE_ADDR  = BASE_ADDR_DEF,
    parameter int          ALLOC_LAT  = 1,
    parameter int          FREE_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_alloc_req,
    input  logic [15:0] i_alloc_data,
    output logic        o_alloc_rdy,
    output logic        o_rsp_valid,
    output logic [15:0] o_rsp_addr,
    input  logic        i_rsp_rdy,
    input  logic        i_free_req,
    input  logic [15:0] i_free_addr,
    output logic        o_free_rdy,
    output logic        o_err,
    output logic        o_alloc,
    output logic [15:0] o_data,
    input  logic [15:0] i_alloc_addr,
    output logic        o_free,
    output logic [15:0] o_addr
);
    logic [1:0]  state;
    logic [15:0] data_q;
    logic [2:0]  lat_cnt;
    logic [2:0]  lat_nxt;
    logic        run_q;
    logic        alloc_take;

    logic        free_take;
    logic        free_win;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [15:0] fifo_head;

    assign alloc_take  = o_alloc_rdy && i_alloc_req;
    assign lat_nxt     = lat_cnt - 3'd1;
    assign o_alloc_rdy = run_q && (state == ST_IDLE);
    assign o_alloc     = (state == ST_ISSUE);
    assign o_data      = o_alloc ? data_q : UNDEF;
    assign o_rsp_valid = (state == ST_RESP);

    // run_q keeps the ready outputs low until the first clock after reset release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            data_q     <= UNDEF;
            lat_cnt    <= '0;
            o_rsp_addr <= UNDEF;
            run_q      <= 1'b0;
        end else begin
            run_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (alloc_take) begin
                        data_q <= i_alloc_data;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    lat_cnt <= 3'(ALLOC_LAT);
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    lat_cnt <= lat_nxt;
                    if (lat_nxt == '0) begin
                        o_rsp_addr <= i_alloc_addr;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_rdy) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_free_rdy = run_q && !fifo_full;
    assign free_take  = i_free_req && o_free_rdy;
    assign free_win   = in_window(i_free_addr, BASE_ADDR, ADDR_SZ);
    assign fifo_push  = free_take && free_win;

    // The free strobe is registered, so a pop decided now lands next cycle,
    // which is the ISSUE cycle whenever an alloc is being accepted now.
`ifdef ALLOC_REQ_COMBINE_EN
    assign fifo_pop = !fifo_empty;
`else
    assign fifo_pop = !fifo_empty && !alloc_take;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_free <= 1'b0;
            o_addr <= UNDEF;
            o_err  <= 1'b0;
        end else begin
            o_free <= fifo_pop;
            o_addr <= fifo_pop ? fifo_head : UNDEF;
            o_err  <= free_take && !free_win;
        end
    end

    alloc_requester_sync_fifo #(
        .WIDTH (16),
        .DEPTH (FREE_DEPTH)
    ) u_free_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (fifo_push),
        .push_data (i_free_addr),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_alloc_requester.sv
// Directed bench for alloc_requester: scoreboard queues for alloc strobes,
// responses and frees, plus cycle-exact checks on the handshake timing.
module tb_alloc_requester;

    logic        i_clk;
    logic        i_rst;
    logic        i_alloc_req;
    logic [15:0] i_alloc_data;
    logic        o_alloc_rdy;
    logic        o_rsp_valid;
    logic [15:0] o_rsp_addr;
    logic        i_rsp_rdy;
    logic        i_free_req;
    logic [15:0] i_free_addr;
    logic        o_free_rdy;
    logic        o_err;
    logic        o_alloc;
    logic [15:0] o_data;
    logic [15:0] i_alloc_addr;
    logic        o_free;
    logic [15:0] o_addr;

    int errors = 0;
    int checks = 0;
    int err_seen = 0;
    int err_exp = 0;
    logic saw_full = 1'b0;

    logic [15:0] alloc_q[$];
    logic [15:0] ret_q[$];
    logic [15:0] rsp_q[$];
    logic [15:0] free_q[$];

    alloc_requester dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_alloc_req  (i_alloc_req),
        .i_alloc_data (i_alloc_data),
        .o_alloc_rdy  (o_alloc_rdy),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_addr   (o_rsp_addr),
        .i_rsp_rdy    (i_rsp_rdy),
        .i_free_req   (i_free_req),
        .i_free_addr  (i_free_addr),
        .o_free_rdy   (o_free_rdy),
        .o_err        (o_err),
        .o_alloc      (o_alloc),
        .o_data       (o_data),
        .i_alloc_addr (i_alloc_addr),
        .o_free       (o_free),
        .o_addr       (o_addr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Allocator model: address valid one cycle after the o_alloc strobe, junk otherwise.
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) i_alloc_addr <= 16'h0000;
        else if (o_alloc && ret_q.size() != 0) i_alloc_addr <= ret_q.pop_front();
        else i_alloc_addr <= 16'hBAD0;
    end

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_alloc) begin
                if (alloc_q.size() == 0) chk("alloc_unexpected", 1, 0);
                else chk("alloc_data", o_data, alloc_q.pop_front());
            end
            if (o_free) begin
                if (free_q.size() == 0) chk("free_unexpected", 1, 0);
                else chk("free_addr", o_addr, free_q.pop_front());
            end else begin
                chk("addr_idle_zero", o_addr, 0);
            end
            if (o_rsp_valid && i_rsp_rdy) begin
                if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
                else chk("rsp_addr", o_rsp_addr, rsp_q.pop_front());
            end
            if (o_err) err_seen++;
            if (i_free_req && !o_free_rdy) saw_full = 1'b1;
`ifndef ALLOC_REQ_COMBINE_EN
            if (o_alloc) chk("alloc_free_overlap", o_free, 0);
`endif
        end
    end

    task automatic host_alloc(input logic [15:0] d, input logic [15:0] ret);
        logic took;
        int n;
        alloc_q.push_back(d);
        ret_q.push_back(ret);
        rsp_q.push_back(ret);
        i_alloc_req = 1'b1;
        i_alloc_data = d;
        took = 1'b0;
        n = 0;
        while (!took && n < 200) begin
            @(negedge i_clk);
            took = o_alloc_rdy;
            @(posedge i_clk); #1;
            n++;
        end
        i_alloc_req = 1'b0;
        if (!took) chk("alloc_accept_timeout", 0, 1);
    endtask

    task automatic free_push(input logic [15:0] a);
        logic took;
        logic [15:0] off;
        int n;
        i_free_req = 1'b1;
        i_free_addr = a;
        took = 1'b0;
        n = 0;
        while (!took && n < 200) begin
            @(negedge i_clk);
            took = o_free_rdy;
            @(posedge i_clk); #1;
            n++;
        end
        i_free_req = 1'b0;
        if (!took) chk("free_accept_timeout", 0, 1);
        off = a - 16'h5000;
        if (off < 16'd16) free_q.push_back(a);
        else err_exp++;
    endtask

    task automatic drain_rsp();
        logic seen;
        int n;
        i_rsp_rdy = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 200) begin
            @(negedge i_clk);
            seen = o_rsp_valid;
            @(posedge i_clk); #1;
            n++;
        end
        i_rsp_rdy = 1'b0;
        if (!seen) chk("rsp_timeout", 0, 1);
    endtask

    initial begin
        i_rst = 1'b1;
        i_alloc_req = 1'b0;
        i_alloc_data = 16'h0000;
        i_rsp_rdy = 1'b0;
        i_free_req = 1'b0;
        i_free_addr = 16'h0000;

        // reset state
        @(negedge i_clk);
        chk("rst_alloc_rdy", o_alloc_rdy, 0);
        chk("rst_free_rdy", o_free_rdy, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_alloc", o_alloc, 0);
        chk("rst_free", o_free, 0);
        chk("rst_err", o_err, 0);
        chk("rst_data", o_data, 0);
        chk("rst_addr", o_addr, 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("post_rst_free_rdy", o_free_rdy, 1);
        chk("post_rst_alloc_rdy", o_alloc_rdy, 1);
        @(posedge i_clk); #1;

        // single alloc, ALLOC_LAT=1: response 3 cycles after accept
        host_alloc(16'h1234, 16'h5001);
        @(negedge i_clk);
        chk("t1_alloc_strobe", o_alloc, 1);
        chk("t1_alloc_data", o_data, 16'h1234);
        chk("t1_alloc_rdy_low", o_alloc_rdy, 0);
        @(negedge i_clk);
        chk("t1_rsp_not_yet", o_rsp_valid, 0);
        chk("t1_alloc_once", o_alloc, 0);
        @(negedge i_clk);
        chk("t1_rsp_valid", o_rsp_valid, 1);
        chk("t1_rsp_addr", o_rsp_addr, 16'h5001);

        // second request held off while the response sits unconsumed
        @(posedge i_clk); #1;
        i_alloc_req = 1'b1;
        i_alloc_data = 16'h5678;
        alloc_q.push_back(16'h5678);
        ret_q.push_back(16'h5002);
        rsp_q.push_back(16'h5002);
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            chk("t2_rsp_held", o_rsp_valid, 1);
            chk("t2_rsp_stable", o_rsp_addr, 16'h5001);
            chk("t2_alloc_rdy_low", o_alloc_rdy, 0);
            chk("t2_no_alloc", o_alloc, 0);
            @(posedge i_clk); #1;
        end
        i_rsp_rdy = 1'b1;
        @(negedge i_clk);
        @(posedge i_clk); #1;
        i_rsp_rdy = 1'b0;
        @(negedge i_clk);
        chk("t2_alloc_rdy_back", o_alloc_rdy, 1);
        @(posedge i_clk); #1;
        i_alloc_req = 1'b0;
        drain_rsp();

        // in-order frees, then an out-of-window free
        free_push(16'h5001);
        free_push(16'h5003);
        free_push(16'h6000);
        @(negedge i_clk);
        chk("t3_err_pulse", o_err, 1);
        @(negedge i_clk);
        chk("t3_err_single", o_err, 0);
        repeat (6) @(posedge i_clk);
        #1;
        chk("t3_frees_drained", free_q.size(), 0);

        // continuous allocs starve the free path until the FIFO fills
        i_rsp_rdy = 1'b1;
        fork
            begin
                for (int k = 0; k < 8; k++)
                    host_alloc(16'hA000 + 16'(k), 16'h5100 + 16'(k));
            end
            begin
                for (int k = 0; k < 20; k++)
                    free_push(16'h5000 + 16'(k % 16));
            end
        join
        repeat (10) @(posedge i_clk);
        #1;
        i_rsp_rdy = 1'b0;
        chk("t4_fifo_filled", saw_full, 1);
        chk("t4_frees_drained", free_q.size(), 0);
        chk("t4_rsps_drained", rsp_q.size(), 0);

        // free queued in the cycle an alloc is accepted
        free_push(16'h5007);
        i_alloc_req = 1'b1;
        i_alloc_data = 16'hC0DE;
        alloc_q.push_back(16'hC0DE);
        ret_q.push_back(16'h5008);
        rsp_q.push_back(16'h5008);
        @(posedge i_clk); #1;
        i_alloc_req = 1'b0;
        @(negedge i_clk);
        chk("t5_alloc_strobe", o_alloc, 1);
`ifdef ALLOC_REQ_COMBINE_EN
        chk("t5_free_with_alloc", o_free, 1);
`else
        chk("t5_free_deferred", o_free, 0);
`endif
        @(negedge i_clk);
        chk("t5_alloc_done", o_alloc, 0);
`ifdef ALLOC_REQ_COMBINE_EN
        chk("t5_free_done", o_free, 0);
`else
        chk("t5_free_next", o_free, 1);
`endif
        drain_rsp();
        repeat (3) @(posedge i_clk);
        #1;

        // reset while WAITing with frees in flight
        i_alloc_req = 1'b1;
        i_alloc_data = 16'hBEEF;
        alloc_q.push_back(16'hBEEF);
        ret_q.push_back(16'h500A);
        i_free_req = 1'b1;
        i_free_addr = 16'h5002;
        @(posedge i_clk); #1;
        i_alloc_req = 1'b0;
        i_free_addr = 16'h5004;
        @(posedge i_clk); #1;
        i_free_req = 1'b0;
        i_rst = 1'b1;
        #1;
        chk("t6_alloc", o_alloc, 0);
        chk("t6_free", o_free, 0);
        chk("t6_addr", o_addr, 0);
        chk("t6_data", o_data, 0);
        chk("t6_rsp_valid", o_rsp_valid, 0);
        chk("t6_rsp_addr", o_rsp_addr, 0);
        chk("t6_alloc_rdy", o_alloc_rdy, 0);
        chk("t6_free_rdy", o_free_rdy, 0);
        chk("t6_err", o_err, 0);
        alloc_q.delete();
        ret_q.delete();
        rsp_q.delete();
        free_q.delete();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        i_rsp_rdy = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge i_clk);
            chk("t6_no_rsp", o_rsp_valid, 0);
            chk("t6_no_free", o_free, 0);
        end
        @(posedge i_clk); #1;
        i_rsp_rdy = 1'b0;

        // recovers with a fresh alloc
        host_alloc(16'h1111, 16'h5009);
        drain_rsp();
        repeat (3) @(posedge i_clk);
        #1;

        chk("end_alloc_q", alloc_q.size(), 0);
        chk("end_rsp_q", rsp_q.size(), 0);
        chk("end_free_q", free_q.size(), 0);
        chk("end_err_count", err_seen, err_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
